// File: rtl/picmicro_pkg.sv
// Shared definitions for the PIC midrange fetch sequencer.
// Contents:
//   PC_OP_*              3-bit encodings of the pc_op opcode classes
//   PICMICRO_*_VECTOR    default reset and interrupt vectors
//   normalize_op()       folds the unused codes 6 and 7 onto NEXT
package picmicro_pkg;

    localparam logic [2:0] PC_OP_NEXT      = 3'd0;
    localparam logic [2:0] PC_OP_SKIP      = 3'd1;
    localparam logic [2:0] PC_OP_GOTO      = 3'd2;
    localparam logic [2:0] PC_OP_CALL      = 3'd3;
    localparam logic [2:0] PC_OP_RETURN    = 3'd4;
    localparam logic [2:0] PC_OP_PCL_WRITE = 3'd5;

    localparam int PICMICRO_RESET_VECTOR = 0;
    localparam int PICMICRO_INT_VECTOR   = 4;

    // Codes above PCL_WRITE carry no meaning and execute as NEXT.
    function automatic logic [2:0] normalize_op(input logic [2:0] op);
        logic [2:0] res;
        if (op > PC_OP_PCL_WRITE) begin
            res = PC_OP_NEXT;
        end else begin
            res = op;
        end
        return res;
    endfunction

endpackage

// File: rtl/picmicro_fetch_sequencer_if.sv
// Bus bundle between the core decode logic and the fetch sequencer.
// master: drives stall, pc_op, target, pclath, pcl_data, irq.
// slave : the sequencer; drives q_phase, instr_rd_en, pc, flush,
//         irq_ack, stack_overflow, stack_underflow.
interface picmicro_fetch_sequencer_if #(
    parameter int PC_WIDTH = 13,
    parameter int Q_PHASES = 4
);
    localparam int Q_W = $clog2(Q_PHASES);

    logic                  stall;
    logic [2:0]            pc_op;
    logic [10:0]           target;
    logic [PC_WIDTH-9:0]   pclath;
    logic [7:0]            pcl_data;
    logic                  irq;
    logic [Q_W-1:0]        q_phase;
    logic                  instr_rd_en;
    logic [PC_WIDTH-1:0]   pc;
    logic                  flush;
    logic                  irq_ack;
    logic                  stack_overflow;
    logic                  stack_underflow;

    modport master (
        output stall, pc_op, target, pclath, pcl_data, irq,
        input  q_phase, instr_rd_en, pc, flush, irq_ack,
               stack_overflow, stack_underflow
    );

    modport slave (
        input  stall, pc_op, target, pclath, pcl_data, irq,
        output q_phase, instr_rd_en, pc, flush, irq_ack,
               stack_overflow, stack_underflow
    );
endinterface

// File: rtl/picmicro_return_stack.sv
// Circular hardware return stack.
// Ports: clk, rst_n (async active-low), push/push_data, pop, top (entry a
// pop returns), overflow/underflow (combinational, valid with push/pop).
// Pushing when full overwrites the oldest entry; popping when empty still
// moves the pointer. Optional macro PICMICRO_STACK_FLAGS_EN builds the
// occupancy counter and the overflow/underflow flags; otherwise both are 0.
module picmicro_return_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             overflow,
    output logic             underflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] sp_r;
    logic [PTR_W-1:0] sp_dec_s;

    assign sp_dec_s = sp_r - PTR_W'(1);
    assign top      = mem_r[sp_dec_s];

    // Stack pointer: wraps freely in both directions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_r <= {PTR_W{1'b0}};
        end else if (push) begin
            sp_r <= sp_r + PTR_W'(1);
        end else if (pop) begin
            sp_r <= sp_dec_s;
        end else begin
            sp_r <= sp_r;
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[sp_r] <= push_data;
        end
    end

`ifdef PICMICRO_STACK_FLAGS_EN
    logic [PTR_W:0] count_r;

    // Occupancy counter saturating at 0 and DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {(PTR_W+1){1'b0}};
        end else if (push && (count_r != (PTR_W+1)'(DEPTH))) begin
            count_r <= count_r + (PTR_W+1)'(1);
        end else if (pop && (count_r != {(PTR_W+1){1'b0}})) begin
            count_r <= count_r - (PTR_W+1)'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign overflow  = push && (count_r == (PTR_W+1)'(DEPTH));
    assign underflow = pop  && (count_r == {(PTR_W+1){1'b0}});
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: rtl/picmicro_fetch_sequencer.sv
// Instruction-cycle sequencer for the PIC midrange core: Q-phase counter,
// program-memory fetch strobe, program counter, return stack, interrupts.
// Ports: clk, rst (async active-low), bus (slave modport of
// picmicro_fetch_sequencer_if, carrying all opcode inputs and outputs).
// Optional macro PICMICRO_STACK_FLAGS_EN enables stack_overflow and
// stack_underflow; without it both outputs stay 0.
module picmicro_fetch_sequencer
    import picmicro_pkg::*;
#(
    parameter int PC_WIDTH     = 13,
    parameter int STACK_DEPTH  = 8,
    parameter int Q_PHASES     = 4,
    parameter int RESET_VECTOR = PICMICRO_RESET_VECTOR,
    parameter int INT_VECTOR   = PICMICRO_INT_VECTOR
) (
    input  logic                        clk,
    input  logic                        rst,
    picmicro_fetch_sequencer_if.slave   bus
);
    localparam int             Q_W    = $clog2(Q_PHASES);
    localparam logic [Q_W-1:0] Q_LAST = Q_W'(Q_PHASES - 1);

    logic [Q_W-1:0]      q_phase_r;
    logic [PC_WIDTH-1:0] pc_r;
    logic                flush_r;

    logic                decide_s;
    logic [PC_WIDTH-1:0] pc_inc_s;
    logic [PC_WIDTH-1:0] goto_pc_s;
    logic [PC_WIDTH-1:0] pc_next_s;
    logic                flush_next_s;
    logic                push_s;
    logic                pop_s;
    logic [PC_WIDTH-1:0] push_data_s;
    logic [PC_WIDTH-1:0] top_s;
    logic                irq_take_s;
    logic                overflow_s;
    logic                underflow_s;

    // Decision operands: the Q4 gate, pc+1, and the paged GOTO/CALL target.
    always_comb begin
        decide_s  = (q_phase_r == Q_LAST) && !bus.stall;
        pc_inc_s  = pc_r + PC_WIDTH'(1);
        // Upper bits come from PCLATH; the low 11 are the literal target.
        goto_pc_s        = {bus.pclath, 8'h00};
        goto_pc_s[10:0]  = bus.target;
    end

    // Q4 decision: next pc, next flush, stack traffic and interrupt take.
    always_comb begin
        pc_next_s    = pc_r;
        flush_next_s = flush_r;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        push_data_s  = pc_r;
        irq_take_s   = 1'b0;
        if (decide_s) begin
            if (flush_r) begin
                // Forced NOP: op and irq ignored.
                pc_next_s    = pc_inc_s;
                flush_next_s = 1'b0;
            end else begin
                case (normalize_op(bus.pc_op))
                    PC_OP_SKIP: begin
                        flush_next_s = 1'b1;
                        if (bus.irq) begin
                            // Skipped word is never executed: resume after it.
                            irq_take_s  = 1'b1;
                            push_s      = 1'b1;
                            push_data_s = pc_inc_s;
                            pc_next_s   = PC_WIDTH'(INT_VECTOR);
                        end else begin
                            pc_next_s   = pc_inc_s;
                        end
                    end
                    PC_OP_GOTO: begin
                        pc_next_s    = goto_pc_s;
                        flush_next_s = 1'b1;
                    end
                    PC_OP_CALL: begin
                        push_s       = 1'b1;
                        push_data_s  = pc_r;
                        pc_next_s    = goto_pc_s;
                        flush_next_s = 1'b1;
                    end
                    PC_OP_RETURN: begin
                        pop_s        = 1'b1;
                        pc_next_s    = top_s;
                        flush_next_s = 1'b1;
                    end
                    PC_OP_PCL_WRITE: begin
                        pc_next_s    = {bus.pclath, bus.pcl_data};
                        flush_next_s = 1'b1;
                    end
                    default: begin
                        if (bus.irq) begin
                            // Fetched word at pc has not executed yet.
                            irq_take_s   = 1'b1;
                            push_s       = 1'b1;
                            push_data_s  = pc_r;
                            pc_next_s    = PC_WIDTH'(INT_VECTOR);
                            flush_next_s = 1'b1;
                        end else begin
                            pc_next_s    = pc_inc_s;
                            flush_next_s = 1'b0;
                        end
                    end
                endcase
            end
        end else begin
            flush_next_s = flush_r;
        end
    end

    // Sequencer state: phase counter, pc and flush, frozen by stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_phase_r <= {Q_W{1'b0}};
            pc_r      <= PC_WIDTH'(RESET_VECTOR);
            flush_r   <= 1'b1;
        end else if (!bus.stall) begin
            q_phase_r <= (q_phase_r == Q_LAST) ? {Q_W{1'b0}} : q_phase_r + Q_W'(1);
            pc_r      <= pc_next_s;
            flush_r   <= flush_next_s;
        end else begin
            q_phase_r <= q_phase_r;
            pc_r      <= pc_r;
            flush_r   <= flush_r;
        end
    end

    picmicro_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (push_data_s),
        .top       (top_s),
        .overflow  (overflow_s),
        .underflow (underflow_s)
    );

    assign bus.q_phase         = q_phase_r;
    assign bus.pc              = pc_r;
    assign bus.flush           = flush_r;
    assign bus.instr_rd_en     = decide_s;
    assign bus.irq_ack         = irq_take_s;
    assign bus.stack_overflow  = overflow_s;
    assign bus.stack_underflow = underflow_s;

endmodule

// File: tb/tb_picmicro_fetch_sequencer.sv
// Self-checking bench for picmicro_fetch_sequencer (default parameters).
// A behavioural model checks every output on every falling edge; directed
// scenarios add literal pc/flush/pulse-count expectations.
module tb_picmicro_fetch_sequencer;
    import picmicro_pkg::*;

    localparam int PCW   = 13;
    localparam int DEPTH = 8;
    localparam int QP    = 4;
`ifdef PICMICRO_STACK_FLAGS_EN
    localparam int FLAGS = 1;
`else
    localparam int FLAGS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    picmicro_fetch_sequencer_if #(.PC_WIDTH(PCW), .Q_PHASES(QP)) bus ();

    picmicro_fetch_sequencer #(
        .PC_WIDTH(PCW), .STACK_DEPTH(DEPTH), .Q_PHASES(QP),
        .RESET_VECTOR(0), .INT_VECTOR(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase, m_sp, m_cnt;
    logic [12:0] m_pc;
    bit          m_flush;
    logic [12:0] m_stk [DEPTH];
    int          n_phase;
    logic [12:0] n_pc, n_pdata;
    bit          n_flush, n_push, n_pop, n_valid;

    task automatic model_reset();
        m_phase = 0; m_pc = 13'h0000; m_flush = 1'b1; m_sp = 0; m_cnt = 0;
    endtask

    initial begin
        int          op;
        bit          dec, take, e_ovf, e_unf;
        logic [12:0] goto_pc;
        for (int i = 0; i < DEPTH; i++) m_stk[i] = 13'h0000;
        model_reset();
        forever begin
            @(negedge clk);
            n_valid = 1'b0;
            if (!rst) begin
                model_reset();
                chk("rst_q_phase", 32'(bus.q_phase), 32'd0);
                chk("rst_pc", 32'(bus.pc), 32'd0);
                chk("rst_flush", 32'(bus.flush), 32'd1);
                chk("rst_instr_rd_en", 32'(bus.instr_rd_en), 32'd0);
                chk("rst_irq_ack", 32'(bus.irq_ack), 32'd0);
                chk("rst_ovf", 32'(bus.stack_overflow), 32'd0);
                chk("rst_unf", 32'(bus.stack_underflow), 32'd0);
            end else begin
                op      = (int'(bus.pc_op) > 5) ? 0 : int'(bus.pc_op);
                dec     = (m_phase == QP - 1) && !bus.stall;
                take    = dec && !m_flush && bus.irq && (op == 0 || op == 1);
                goto_pc = {bus.pclath[4:3], bus.target};
                n_phase = bus.stall ? m_phase : (m_phase + 1) % QP;
                n_pc = m_pc; n_flush = m_flush; n_push = 1'b0; n_pop = 1'b0; n_pdata = m_pc;
                if (dec) begin
                    if (m_flush) begin
                        n_pc = m_pc + 13'd1; n_flush = 1'b0;
                    end else if (take) begin
                        n_push = 1'b1; n_pdata = (op == 1) ? m_pc + 13'd1 : m_pc;
                        n_pc = 13'd4; n_flush = 1'b1;
                    end else begin
                        n_flush = 1'b1;
                        case (op)
                            1: n_pc = m_pc + 13'd1;
                            2: n_pc = goto_pc;
                            3: begin n_push = 1'b1; n_pc = goto_pc; end
                            4: n_pop = 1'b1;
                            5: n_pc = {bus.pclath, bus.pcl_data};
                            default: begin n_pc = m_pc + 13'd1; n_flush = 1'b0; end
                        endcase
                    end
                end
                e_ovf = (FLAGS == 1) && n_push && (m_cnt == DEPTH);
                e_unf = (FLAGS == 1) && n_pop && (m_cnt == 0);
                chk("q_phase", 32'(bus.q_phase), 32'(m_phase));
                chk("pc", 32'(bus.pc), 32'(m_pc));
                chk("flush", 32'(bus.flush), 32'(m_flush));
                chk("instr_rd_en", 32'(bus.instr_rd_en), 32'(dec));
                chk("irq_ack", 32'(bus.irq_ack), 32'(take));
                chk("stack_overflow", 32'(bus.stack_overflow), 32'(e_ovf));
                chk("stack_underflow", 32'(bus.stack_underflow), 32'(e_unf));
                n_valid = 1'b1;
            end
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset();
            end else if (n_valid) begin
                m_phase = n_phase; m_flush = n_flush;
                if (n_push) begin
                    m_stk[m_sp] = n_pdata; m_sp = (m_sp + 1) % DEPTH;
                    if (m_cnt < DEPTH) m_cnt++;
                    m_pc = n_pc;
                end else if (n_pop) begin
                    m_sp = (m_sp + DEPTH - 1) % DEPTH; m_pc = m_stk[m_sp];
                    if (m_cnt > 0) m_cnt--;
                end else begin
                    m_pc = n_pc;
                end
            end
        end
    end

    // ---------------- pulse counters ----------------
    int ack_cnt = 0, ovf_cnt = 0, unf_cnt = 0;
    always @(negedge clk) begin
        if (bus.irq_ack)         ack_cnt <= ack_cnt + 1;
        if (bus.stack_overflow)  ovf_cnt <= ovf_cnt + 1;
        if (bus.stack_underflow) unf_cnt <= unf_cnt + 1;
    end

    // ---------------- directed stimulus ----------------
    // Called at posedge+1 of phase 0; returns one instruction cycle later.
    task automatic instr(input logic [2:0] op, input logic [10:0] tgt,
                         input logic [4:0] lath, input logic [7:0] pd, input logic irq_i);
        bus.pc_op = op; bus.target = tgt; bus.pclath = lath; bus.pcl_data = pd; bus.irq = irq_i;
        repeat (QP) @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input string name, input logic [12:0] e_pc, input logic e_flush);
        chk({name, "_pc"}, 32'(bus.pc), 32'(e_pc));
        chk({name, "_flush"}, 32'(bus.flush), 32'(e_flush));
    endtask

    initial begin
        bus.stall = 1'b0; bus.pc_op = PC_OP_NEXT; bus.target = 11'h000;
        bus.pclath = 5'h00; bus.pcl_data = 8'h00; bus.irq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_pc("reset", 13'h0000, 1'b1);
        chk("reset_q_phase", 32'(bus.q_phase), 32'd0);
        rst = 1'b1;

        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);   expect_pc("first_nop", 13'h0001, 1'b0);
        instr(3'd7,       11'h000, 5'h00, 8'h00, 1'b0);   expect_pc("op7_next", 13'h0002, 1'b0);
        instr(PC_OP_GOTO, 11'h123, 5'h18, 8'h00, 1'b0);   expect_pc("goto", 13'h1923, 1'b1);
        instr(PC_OP_CALL, 11'h456, 5'h1F, 8'h00, 1'b0);   expect_pc("goto_flushed", 13'h1924, 1'b0);
        instr(PC_OP_PCL_WRITE, 11'h000, 5'h02, 8'h34, 1'b0); expect_pc("pcl_write", 13'h0234, 1'b1);
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);   expect_pc("pcl_flushed", 13'h0235, 1'b0);

        instr(PC_OP_GOTO, 11'h00F, 5'h00, 8'h00, 1'b0);
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);   expect_pc("pre_skip", 13'h0010, 1'b0);
        instr(PC_OP_SKIP, 11'h000, 5'h00, 8'h00, 1'b0);   expect_pc("skip", 13'h0011, 1'b1);
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);   expect_pc("skip_after", 13'h0012, 1'b0);

        // Interrupt during NEXT at pc 0x050.
        instr(PC_OP_GOTO, 11'h04F, 5'h00, 8'h00, 1'b0);
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);   expect_pc("pre_irq", 13'h0050, 1'b0);
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b1);   expect_pc("irq_vector", 13'h0004, 1'b1);
        chk("irq_ack_count1", 32'(ack_cnt), 32'd1);
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);   expect_pc("isr", 13'h0005, 1'b0);
        instr(PC_OP_RETURN, 11'h000, 5'h00, 8'h00, 1'b0); expect_pc("irq_return", 13'h0050, 1'b1);
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);   expect_pc("irq_resume", 13'h0051, 1'b0);

        // Interrupt held through GOTO and its flush: taken one cycle later.
        instr(PC_OP_GOTO, 11'h100, 5'h00, 8'h00, 1'b1);   expect_pc("irq_goto", 13'h0100, 1'b1);
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b1);   expect_pc("irq_flushed", 13'h0101, 1'b0);
        chk("irq_ack_deferred", 32'(ack_cnt), 32'd1);
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b1);   expect_pc("irq_late", 13'h0004, 1'b1);
        chk("irq_ack_count2", 32'(ack_cnt), 32'd2);
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);
        instr(PC_OP_RETURN, 11'h000, 5'h00, 8'h00, 1'b0); expect_pc("irq_late_ret", 13'h0101, 1'b1);
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);   expect_pc("pre_stall", 13'h0102, 1'b0);

        // Stall for 6 clocks starting at phase 2.
        repeat (2) @(posedge clk);
        #1;
        bus.stall = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("stall_q_phase", 32'(bus.q_phase), 32'd2);
        chk("stall_pc", 32'(bus.pc), 32'h102);
        bus.stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_pc("post_stall", 13'h0103, 1'b0);

        // Nine nested calls, then nine returns.
        for (int k = 0; k < 9; k++) begin
            instr(PC_OP_CALL, 11'(11'h200 + 11'(k * 16)), 5'h00, 8'h00, 1'b0);
            instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);
        end
        expect_pc("calls_done", 13'h0281, 1'b0);
        chk("overflow_count", 32'(ovf_cnt), 32'(FLAGS));
        instr(PC_OP_RETURN, 11'h000, 5'h00, 8'h00, 1'b0); expect_pc("ret1", 13'h0271, 1'b1);
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);
        for (int k = 1; k < 8; k++) begin
            instr(PC_OP_RETURN, 11'h000, 5'h00, 8'h00, 1'b0);
            instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);
        end
        expect_pc("ret8", 13'h0202, 1'b0);
        chk("underflow_count_pre", 32'(unf_cnt), 32'd0);
        instr(PC_OP_RETURN, 11'h000, 5'h00, 8'h00, 1'b0); expect_pc("ret9_wrap", 13'h0271, 1'b1);
        chk("underflow_count", 32'(unf_cnt), 32'(FLAGS));
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);

        // Reset in phase 3 while a CALL is presented.
        bus.pc_op = PC_OP_CALL; bus.target = 11'h3AA;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        expect_pc("midreset", 13'h0000, 1'b1);
        chk("midreset_q_phase", 32'(bus.q_phase), 32'd0);
        chk("midreset_ovf", 32'(bus.stack_overflow), 32'd0);
        chk("midreset_unf", 32'(bus.stack_underflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);   expect_pc("after_reset", 13'h0001, 1'b0);
        instr(PC_OP_RETURN, 11'h000, 5'h00, 8'h00, 1'b0);
        chk("reset_empties_stack", 32'(unf_cnt), 32'(2 * FLAGS));
        instr(PC_OP_NEXT, 11'h000, 5'h00, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/picmicro_fetch_sequencer.md
# picmicro_fetch_sequencer

Parametrised instruction-cycle sequencer for the PIC midrange core. It generates the Q-phase clocking, drives program-memory fetch enables and owns the program counter. It also owns the hardware return stack and the interrupt vectoring. Sequencing supports single-cycle and two-cycle (flushed) instructions and replaces the core's hard-wired 4-clock/8-clock instruction timing.

## Interface
- PC_WIDTH, 13: program counter width; legal range 11..16.
- STACK_DEPTH, 8: return-stack entries; power of two, at least 2.
- Q_PHASES, 4: clocks per instruction cycle; at least 2.
- RESET_VECTOR, 0: PC value after reset.
- INT_VECTOR, 4: PC value loaded when an interrupt is taken.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  freezes the sequencer while high.
- pc_op  in  3  opcode class: 0 NEXT, 1 SKIP, 2 GOTO, 3 CALL, 4 RETURN, 5 PCL_WRITE; 6 and 7 are treated as NEXT.
- target  in  11  GOTO/CALL literal.
- pclath  in  PC_WIDTH-8  PCLATH register value.
- pcl_data  in  8  data written to PCL.
- irq  in  1  level interrupt request.
- q_phase  out  $clog2(Q_PHASES)  current phase.
- instr_rd_en  out  1  program-memory latch strobe.
- pc  out  PC_WIDTH  fetch address.
- flush  out  1  current instruction cycle executes a forced NOP.
- irq_ack  out  1  one-clock pulse when an interrupt is taken.
- stack_overflow  out  1  one-clock pulse (see Configuration).
- stack_underflow  out  1  one-clock pulse (see Configuration).

## Operation
- **Phase counter:** q_phase counts 0..Q_PHASES-1 and wraps. The last phase is called Q4.
- **Decision point:** pc_op, target, pclath, pcl_data and irq are sampled only on the Q4 clock. All PC, stack and flush updates happen on the Q4 edge.
- **Fetch:** instr_rd_en is high during Q4 only, latching the word at the current pc. pc always holds the address of the word being fetched, which is the executing address + 1.
- **NEXT:** pc <= pc+1; flush <= 0.
- **SKIP:** pc <= pc+1; flush <= 1.
- **GOTO:** pc <= {pclath[PC_WIDTH-9:3], target}; flush <= 1.
- **CALL:** push pc, then do the GOTO load; flush <= 1.
- **RETURN:** pc <= pop; flush <= 1.
- **PCL_WRITE:** pc <= {pclath, pcl_data}; flush <= 1.
- **Interrupts:** irq is taken only when the sampled op is NEXT or SKIP and flush is 0. When taken:
  - push pc+1 (SKIP) or pc (NEXT);
  - pc <= INT_VECTOR; flush <= 1;
  - irq_ack pulses on the Q4 edge.
- **Interrupts not taken:** with any other op, or during a flushed cycle, irq is ignored and re-sampled at the next Q4.
- **Flushed cycle:** the op presented during it is ignored and treated as NEXT; flush then clears.
- **Overflow:** push when STACK_DEPTH entries are held overwrites the oldest entry (circular pointer); the count stays at STACK_DEPTH.
- **Underflow:** pop when empty returns the entry at the decremented wrapped pointer; the count stays 0.
- **PC arithmetic:** pc+1 is modulo 2^PC_WIDTH.

## Timing
- Reset values: q_phase=0, pc=RESET_VECTOR, flush=1, instr_rd_en=0, irq_ack=0, stack_overflow=0, stack_underflow=0, stack empty.
- The first instruction cycle after reset is a forced NOP that fetches RESET_VECTOR.
- Instruction cost: NEXT costs 1 instruction cycle (Q_PHASES clocks). Any flushing op, or a taken irq, costs 2 instruction cycles.
- Stall: while stall=1, q_phase, pc, stack and flush hold, and instr_rd_en, irq_ack and the flags are 0. A stall asserted on the Q4 clock suppresses that decision until stall drops.
- Reset mid-cycle: all state returns to reset values immediately (asynchronous). Stack contents are don't-care.
- Flags: stack_overflow and stack_underflow pulse for exactly the Q4 clock of the offending push or pop.

## Configuration
- PICMICRO_STACK_FLAGS_EN defined: overflow/underflow detection logic and the occupancy counter are built; stack_overflow and stack_underflow pulse as specified.
- Macro undefined: the counter is removed and both flag outputs are tied 0. Wrap behaviour is identical either way.

## Structure
- Shared package picmicro_pkg holds:
  - pc_op encodings as localparam constants (PC_OP_NEXT .. PC_OP_PCL_WRITE);
  - the default vector constants.
- Sub-module picmicro_return_stack, parametrised by DEPTH and WIDTH, provides push, pop, top, and (under the macro) overflow/underflow.

## Test plan
- Reset release, all NEXT → q_phase 0,1,2,3 repeating; instr_rd_en high on phase 3 only; pc 0→1→2 on successive Q4 edges; flush=1 for the first cycle only.
- GOTO target=0x123, pclath=0x18 → pc=0x1923; flush=1 for the next 4 clocks; the op presented during those clocks is ignored.
- PCL_WRITE pclath=0x02, pcl_data=0x34 → pc=0x0234. SKIP at pc=0x010 → pc=0x011 with flush=1, then 0x012.
- Nine nested CALLs → stack_overflow pulses on the 9th push. Nine RETURNs → stack_underflow pulses on the 9th pop. With the macro undefined, both flags stay 0.
- irq=1 during NEXT with pc=0x050 → pc=0x004, irq_ack pulses once, next RETURN gives pc=0x050. irq during GOTO → not taken until the Q4 after the flush.
- stall held 6 clocks from phase 2 → q_phase stays 2, pc unchanged. rst asserted at phase 3 mid-CALL → pc=RESET_VECTOR, no push, flags 0.
